// File: rtl/i2c_arbiter.sv
// Two-port round-robin front end that shares a single-byte I2C master between requesters A and B.
// Define I2C_ARBITER_RETRY_EN to re-issue NACKed transfers up to MAX_RETRY times.
module i2c_arbiter #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_rw,
    input  logic [7:0] a_din,
    output logic       a_gnt,
    output logic       a_done,
    output logic       a_err,
    output logic [7:0] a_dout,
    input  logic       b_req,
    input  logic       b_rw,
    input  logic [7:0] b_din,
    output logic       b_gnt,
    output logic       b_done,
    output logic       b_err,
    output logic [7:0] b_dout,
    output logic       m_rw,
    output logic       m_dataValid,
    output logic [6:0] m_addr,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ackErr
);

    localparam int              TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
`ifdef I2C_ARBITER_RETRY_EN
        , S_RETRY
`endif
    } state_t;

    state_t        r_state, w_state_next;
    logic          r_sel_b, w_sel_b_next;
    logic          r_last_b, w_last_b_next;
    logic [TW-1:0] r_tcnt, w_tcnt_next;
    logic          r_m_rw, w_m_rw_next;
    logic [6:0]    r_m_addr, w_m_addr_next;
    logic [7:0]    r_m_din, w_m_din_next;
    logic          r_m_valid, w_m_valid_next;
    logic          w_gnt_a_next, w_gnt_b_next, w_pick_b;
    logic          w_resp, w_resp_err;
    logic [7:0]    w_resp_data;
    logic          r_a_gnt, r_a_done, r_a_err, r_b_gnt, r_b_done, r_b_err;
    logic [7:0]    r_a_dout, r_b_dout;
`ifdef I2C_ARBITER_RETRY_EN
    localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);
    logic [2:0]    r_retry, w_retry_next;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_sel_b_next   = r_sel_b;
        w_last_b_next  = r_last_b;
        w_tcnt_next    = r_tcnt;
        w_m_rw_next    = r_m_rw;
        w_m_addr_next  = r_m_addr;
        w_m_din_next   = r_m_din;
        w_m_valid_next = 1'b0;
        w_gnt_a_next   = 1'b0;
        w_gnt_b_next   = 1'b0;
        w_resp         = 1'b0;
        w_resp_err     = 1'b0;
        w_resp_data    = 8'h00;
        // B wins only when alone, or when A was the port served last.
        w_pick_b       = b_req && (!a_req || !r_last_b);
`ifdef I2C_ARBITER_RETRY_EN
        w_retry_next   = r_retry;
`endif
        case (r_state)
            S_IDLE: begin
                w_tcnt_next = '0;
`ifdef I2C_ARBITER_RETRY_EN
                w_retry_next = 3'd0;
`endif
                if ((a_req || b_req) && !m_busy) begin
                    w_sel_b_next  = w_pick_b;
                    w_gnt_a_next  = !w_pick_b;
                    w_gnt_b_next  = w_pick_b;
                    w_m_rw_next   = w_pick_b ? b_rw : a_rw;
                    w_m_din_next  = w_pick_b ? b_din : a_din;
                    w_m_addr_next = SLAVE_ADDR;
                    w_state_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_m_valid_next = 1'b1;
                w_tcnt_next    = '0;
                w_state_next   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (m_done) begin
                    if (!m_ackErr) begin
                        w_resp       = 1'b1;
                        w_resp_data  = r_m_rw ? m_dout : 8'h00;
                        w_state_next = S_RESP;
                    end
`ifdef I2C_ARBITER_RETRY_EN
                    else if (r_retry < MAX_RETRY_L) begin
                        w_retry_next = r_retry + 3'd1;
                        w_state_next = S_RETRY;
                    end
`endif
                    else begin
                        w_resp       = 1'b1;
                        w_resp_err   = 1'b1;
                        w_state_next = S_RESP;
                    end
                end else if (r_tcnt == TLIM) begin
                    w_resp       = 1'b1;
                    w_resp_err   = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_tcnt_next = r_tcnt + TW'(1);
                end
            end
`ifdef I2C_ARBITER_RETRY_EN
            S_RETRY: begin
                if (!m_busy) w_state_next = S_ISSUE;
            end
`endif
            S_RESP: begin
                w_last_b_next = r_sel_b;
                w_m_rw_next   = 1'b0;
                w_m_addr_next = 7'h00;
                w_m_din_next  = 8'h00;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sel_b   <= 1'b0;
            r_last_b  <= 1'b1;
            r_tcnt    <= '0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= 7'h00;
            r_m_din   <= 8'h00;
            r_m_valid <= 1'b0;
            r_a_gnt   <= 1'b0;
            r_a_done  <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_dout  <= 8'h00;
            r_b_gnt   <= 1'b0;
            r_b_done  <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_dout  <= 8'h00;
`ifdef I2C_ARBITER_RETRY_EN
            r_retry   <= 3'd0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_sel_b   <= w_sel_b_next;
            r_last_b  <= w_last_b_next;
            r_tcnt    <= w_tcnt_next;
            r_m_rw    <= w_m_rw_next;
            r_m_addr  <= w_m_addr_next;
            r_m_din   <= w_m_din_next;
            r_m_valid <= w_m_valid_next;
            r_a_gnt   <= w_gnt_a_next;
            r_b_gnt   <= w_gnt_b_next;
            r_a_done  <= w_resp & ~r_sel_b;
            r_a_err   <= w_resp & w_resp_err & ~r_sel_b;
            r_a_dout  <= r_sel_b ? 8'h00 : w_resp_data;
            r_b_done  <= w_resp & r_sel_b;
            r_b_err   <= w_resp & w_resp_err & r_sel_b;
            r_b_dout  <= r_sel_b ? w_resp_data : 8'h00;
`ifdef I2C_ARBITER_RETRY_EN
            r_retry   <= w_retry_next;
`endif
        end
    end

    assign a_gnt       = r_a_gnt;
    assign a_done      = r_a_done;
    assign a_err       = r_a_err;
    assign a_dout      = r_a_dout;
    assign b_gnt       = r_b_gnt;
    assign b_done      = r_b_done;
    assign b_err       = r_b_err;
    assign b_dout      = r_b_dout;
    assign m_rw        = r_m_rw;
    assign m_dataValid = r_m_valid;
    assign m_addr      = r_m_addr;
    assign m_din       = r_m_din;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: stimulus queues expected transactions, a monitor checks grants,
// master strobes and completions against them; a small slave model answers the master strobe.
module tb_i2c_arbiter;

`ifdef I2C_ARBITER_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_rw, b_req, b_rw;
    logic [7:0] a_din, b_din;
    logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [7:0] a_dout, b_dout;
    logic       m_rw, m_dataValid, m_busy, m_done, m_ackErr;
    logic [6:0] m_addr;
    logic [7:0] m_din, m_dout;

    always #5 clk = ~clk;

    i2c_arbiter #(.SLAVE_ADDR(7'h50), .MAX_RETRY(3), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_rw(a_rw), .a_din(a_din), .a_gnt(a_gnt), .a_done(a_done),
        .a_err(a_err), .a_dout(a_dout),
        .b_req(b_req), .b_rw(b_rw), .b_din(b_din), .b_gnt(b_gnt), .b_done(b_done),
        .b_err(b_err), .b_dout(b_dout),
        .m_rw(m_rw), .m_dataValid(m_dataValid), .m_addr(m_addr), .m_din(m_din),
        .m_dout(m_dout), .m_busy(m_busy), .m_done(m_done), .m_ackErr(m_ackErr)
    );

    typedef struct {
        logic       port_b;
        logic       rw;
        logic [7:0] din;
        logic       err;
        logic [7:0] dout;
        int         pulses;
        int         kind;   // 0: done one cycle after m_done, 1: timeout 100 cycles after strobe
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_total = 0;
    int         valid_total = 0;
    int         pulses_seen = 0;
    int         valid_cyc = 0;
    int         mdone_cyc = 0;
    int         nack_left = 0;
    logic       model_silent = 1'b0;
    logic [7:0] model_rdata = 8'h3C;
    logic       drop_a_on_gnt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic pb, input logic rw, input logic [7:0] din, input logic err,
                        input logic [7:0] dout, input int pulses, input int kind);
        exp_t x;
        x.port_b = pb; x.rw = rw; x.din = din; x.err = err;
        x.dout = dout; x.pulses = pulses; x.kind = kind;
        sb.push_back(x);
    endtask

    // Waits for the completion count, releasing requests on done (or on grant when asked to).
    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_total < target && n < budget) begin
            @(negedge clk);
            if (a_done || (a_gnt && drop_a_on_gnt)) a_req = 1'b0;
            if (b_done) b_req = 1'b0;
            n++;
        end
        check("wait_done", done_total, target);
    endtask

    // Slave model: busy from strobe until its done cycle, optional NACKs, or silence.
    initial begin
        m_done = 1'b0; m_ackErr = 1'b0; m_busy = 1'b0; m_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (rst && m_dataValid && !model_silent) begin
                m_busy = 1'b1;
                repeat (3) @(negedge clk);
                m_done   = 1'b1;
                m_ackErr = (nack_left > 0);
                if (nack_left > 0) nack_left--;
                m_dout    = model_rdata;
                mdone_cyc = cyc;
                @(negedge clk);
                m_done = 1'b0; m_ackErr = 1'b0; m_busy = 1'b0; m_dout = 8'h00;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (a_gnt || b_gnt) begin
                    if (sb.size() == 0) check("unexpected_gnt", {a_gnt, b_gnt}, 0);
                    else begin
                        check("gnt_port", {a_gnt, b_gnt}, sb[0].port_b ? 2'b01 : 2'b10);
                        check("gnt_no_done", {a_done, b_done}, 0);
                    end
                end
                if (m_dataValid) begin
                    valid_total++;
                    pulses_seen++;
                    valid_cyc = cyc;
                    if (sb.size() == 0) check("unexpected_valid", m_dataValid, 0);
                    else begin
                        check("m_rw", m_rw, sb[0].rw);
                        check("m_addr", m_addr, 7'h50);
                        check("m_din", m_din, sb[0].din);
                    end
                end
                if (a_done || b_done) begin
                    done_total++;
                    if (sb.size() == 0) check("unexpected_done", {a_done, b_done}, 0);
                    else begin
                        e = sb.pop_front();
                        check("done_port", {a_done, b_done}, e.port_b ? 2'b01 : 2'b10);
                        check("err", {a_err, b_err}, e.err ? (e.port_b ? 2'b01 : 2'b10) : 2'b00);
                        check("dout", e.port_b ? b_dout : a_dout, e.dout);
                        check("strobes", pulses_seen, e.pulses);
                        if (e.kind == 0) check("done_latency", cyc - mdone_cyc, 1);
                        else             check("timeout_latency", cyc - valid_cyc, 100);
                        $display("txn %0d port=%s rw=%0d err=%0d dout=%02h strobes=%0d",
                                 done_total, e.port_b ? "B" : "A", e.rw, a_err | b_err,
                                 e.port_b ? b_dout : a_dout, pulses_seen);
                    end
                    pulses_seen = 0;
                end
            end
        end
    end

    initial begin
        int v0, d0;
        rst = 1'b0;
        a_req = 1'b1; a_rw = 1'b0; a_din = 8'h11;
        b_req = 1'b1; b_rw = 1'b1; b_din = 8'h22;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, m_rw, m_dataValid}, 0);
        check("rst_data", {a_dout, b_dout, m_din}, 0);
        check("rst_addr", m_addr, 0);

        // Simultaneous requests from reset: A, then B; next pair A, then B.
        push(1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 1, 0);
        push(1'b1, 1'b1, 8'h22, 1'b0, 8'h3C, 1, 0);
        rst = 1'b1;
        wait_done(2, 200);
        a_din = 8'h33; b_rw = 1'b0; b_din = 8'h44;
        a_req = 1'b1; b_req = 1'b1;
        push(1'b0, 1'b0, 8'h33, 1'b0, 8'h00, 1, 0);
        push(1'b1, 1'b0, 8'h44, 1'b0, 8'h00, 1, 0);
        wait_done(4, 200);

        // Lone B read with pointer at "B served last".
        b_rw = 1'b1; b_din = 8'h55; b_req = 1'b1;
        push(1'b1, 1'b1, 8'h55, 1'b0, 8'h3C, 1, 0);
        wait_done(5, 200);

        // A write 0xA5.
        a_rw = 1'b0; a_din = 8'hA5; a_req = 1'b1;
        push(1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1, 0);
        wait_done(6, 200);

        // Persistent NACK on a B read.
        nack_left = 4;
        b_rw = 1'b1; b_din = 8'h66; b_req = 1'b1;
        push(1'b1, 1'b1, 8'h66, 1'b1, 8'h00, RETRY_EN ? 4 : 1, 0);
        wait_done(7, 400);
        nack_left = 0;

        // Two NACKs then ACK on an A read.
        nack_left = 2; model_rdata = 8'hC9;
        a_rw = 1'b1; a_din = 8'h77; a_req = 1'b1;
        if (RETRY_EN) push(1'b0, 1'b1, 8'h77, 1'b0, 8'hC9, 3, 0);
        else          push(1'b0, 1'b1, 8'h77, 1'b1, 8'h00, 1, 0);
        wait_done(8, 400);
        nack_left = 0;

        // Silent slave: timeout error.
        model_silent = 1'b1;
        a_rw = 1'b0; a_din = 8'h5A; a_req = 1'b1;
        push(1'b0, 1'b0, 8'h5A, 1'b1, 8'h00, 1, 1);
        wait_done(9, 2000);
        model_silent = 1'b0;

        // Request dropped right after grant still completes.
        drop_a_on_gnt = 1'b1; model_rdata = 8'h96;
        a_rw = 1'b1; a_din = 8'h00; a_req = 1'b1;
        push(1'b0, 1'b1, 8'h00, 1'b0, 8'h96, 1, 0);
        wait_done(10, 200);
        drop_a_on_gnt = 1'b0;

        // Reset while waiting for the master.
        model_silent = 1'b1;
        a_rw = 1'b0; a_din = 8'hE7; a_req = 1'b1;
        push(1'b0, 1'b0, 8'hE7, 1'b0, 8'h00, 1, 0);
        v0 = valid_total;
        for (int n = 0; n < 50 && valid_total == v0; n++) @(negedge clk);
        check("abort_issued", valid_total - v0, 1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ctrl", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, m_rw, m_dataValid}, 0);
        check("abort_data", {a_dout, b_dout, m_din}, 0);
        check("abort_addr", m_addr, 0);
        sb.delete();
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d0 = done_total; v0 = valid_total;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_total - d0, 0);
        check("abort_no_strobe", valid_total - v0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
- REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit target address driven on m_addr for every transaction.
- REQ-002 SHALL have parameter MAX_RETRY, default 3: re-issues allowed after an ackErr (range 0-7).
- REQ-003 SHALL have parameter TIMEOUT, default 65535: clk cycles allowed between m_dataValid and m_done.
- REQ-004 SHALL have ports, clock and reset first:
  - clk  in  1  system clock.
  - rst  in  1  reset, asynchronous, active-low.
  - a_req  in  1  port A request level.
  - a_rw  in  1  port A 1:read, 0:write.
  - a_din  in  8  port A write byte.
  - a_gnt  out  1  port A grant pulse.
  - a_done  out  1  port A completion pulse.
  - a_err  out  1  port A error, valid with a_done.
  - a_dout  out  8  port A read byte, valid with a_done.
  - b_*: same seven ports for port B.
  - m_rw  out  1  master rw.
  - m_dataValid  out  1  master start strobe.
  - m_addr  out  7  master slave address.
  - m_din  out  8  master write byte.
  - m_dout  in  8  master read byte.
  - m_busy  in  1  master busy.
  - m_done  in  1  master done.
  - m_ackErr  in  1  master NACK flag.

Function
- REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> RESP -> IDLE, plus RETRY.
- REQ-006 IDLE: with any req high and m_busy low, SHALL select one port, latch its rw/din, pulse its gnt for 1 cycle and enter ISSUE next cycle.
- REQ-007 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not served last; with a single request, grant it regardless of pointer.
- REQ-008 ISSUE: SHALL assert m_dataValid for exactly 1 cycle with m_addr=SLAVE_ADDR, m_rw/m_din = latched values, then enter WAIT_DONE.
- REQ-009 m_rw, m_addr, m_din SHALL hold stable from ISSUE until RESP exits.
- REQ-010 WAIT_DONE: on m_done with m_ackErr low SHALL capture m_dout (read) and enter RESP with err=0.
- REQ-011 WAIT_DONE: on m_done with m_ackErr high SHALL enter RETRY when retry count < MAX_RETRY, else RESP with err=1.
- REQ-012 RETRY: SHALL increment retry count, wait until m_busy low, then re-enter ISSUE with unchanged latched data.
- REQ-013 WAIT_DONE: timeout counter reaching TIMEOUT without m_done SHALL enter RESP with err=1; timeout is not retried.
- REQ-014 RESP: SHALL pulse the granted port's done for 1 cycle, with err and dout (read byte, or 8'h00 on write/error) valid that cycle; update the round-robin pointer; return to IDLE.
- REQ-015 Latency: req seen in IDLE -> m_dataValid 2 cycles later; m_done -> port done 1 cycle later.
- REQ-016 Requesters SHALL keep req high until done; a req dropped after gnt SHALL NOT abort the transaction, and the result is still pulsed.
- REQ-017 A port SHALL NOT be re-granted in the cycle of its own done pulse; earliest re-grant is the next IDLE cycle.
- REQ-018 gnt, done and err of the non-granted port SHALL stay 0 throughout.

Reset
- REQ-019 rst low SHALL asynchronously force state IDLE, all outputs 0, retry/timeout counters 0, and the round-robin pointer to "B served last" (port A wins first tie).
- REQ-020 Reset mid-transaction SHALL drop m_dataValid immediately and discard the transaction, with no done pulse.

Configuration
- REQ-021 Macro I2C_ARBITER_RETRY_EN defined: RETRY state and REQ-011/REQ-012 behaviour SHALL be present.
- REQ-022 Macro I2C_ARBITER_RETRY_EN undefined: RETRY state, retry counter and MAX_RETRY logic SHALL be absent, and any ackErr SHALL go directly to RESP with err=1.

Verification
- REQ-023 Scenario: a_req, write, a_din=8'hA5, model acks -> m_din=8'hA5, m_rw=0, m_addr=7'h50, a_done=1, a_err=0.
- REQ-024 Scenario: a_req and b_req both high from reset -> A granted first, B second; a new simultaneous pair afterwards -> A is granted next (B was served last), alternating A, B, A, B.
- REQ-025 Scenario: b read, model returns 8'h3C -> b_dout=8'h3C, b_done 1 cycle after m_done.
- REQ-026 Scenario: model NACKs 4 times, RETRY_EN defined, MAX_RETRY=3 -> 4 m_dataValid pulses, then b_err=1; same stimulus without macro -> 1 pulse, b_err=1.
- REQ-027 Scenario: model never asserts m_done, TIMEOUT=100 -> a_done with a_err=1 exactly 100 cycles after WAIT_DONE entry.
- REQ-028 Scenario: rst low in WAIT_DONE -> all outputs 0 within the same cycle; no done pulse after release.
